renode_axi_manager_arbiter: RTL and testbench

Shares one single-beat AXI4 manager port between `NumRequesters` requester ports. Read and write paths each have an independent round-robin arbiter. Each path allows one outstanding transaction and routes the response back to the granted requester. The block sits between several co-simulation or DMA-style requesters and one AXI subordinate, for example the HWPE memory.

---
 rtl/renode_axi_pkg.sv | 29 ++
 rtl/renode_axi_rr_arbiter.sv | 42 ++++
 rtl/renode_axi_manager_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_renode_axi_manager_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_axi_pkg.sv
// Shared AXI types for the Renode co-simulation bridge blocks.
// Includes the arbiter FSM state encodings.
package renode_axi_pkg;

  typedef logic [2:0] burst_size_t;
  typedef logic [1:0] burst_type_t;

  localparam burst_type_t Incrementing = 2'b01;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } response_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdAddr,
    RdResp
  } arb_rd_state_e;

  typedef enum logic [1:0] {
    WrIdle,
    WrAddrData,
    WrResp
  } arb_wr_state_e;

endpackage

// File: rtl/renode_axi_rr_arbiter.sv
// N-way round-robin picker: lowest requesting index at or after the
// pointer wins; advance moves the pointer just past the current winner.
module renode_axi_rr_arbiter
  import renode_axi_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = IW'((int'(r_ptr) + i) % N);
      if (req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && grant_valid) begin
      r_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/renode_axi_manager_arbiter.sv
// Shares one single-beat AXI4 manager port among several requesters,
// with independent round-robin read and write paths.
module renode_axi_manager_arbiter
  import renode_axi_pkg::*;
#(
  parameter int NumRequesters      = 4,
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8,
  localparam int StrobeWidth = DataWidth / 8,
  localparam int GW = $clog2(NumRequesters)
) (
  input  logic aclk,
  input  logic areset,

  input  logic [NumRequesters-1:0]                         s_arvalid,
  output logic [NumRequesters-1:0]                         s_arready,
  input  logic [NumRequesters-1:0][AddressWidth-1:0]       s_araddr,
  input  logic [NumRequesters-1:0][TransactionIdWidth-1:0] s_arid,
  input  burst_size_t [NumRequesters-1:0]                  s_arsize,
  output logic [NumRequesters-1:0]                         s_rvalid,
  input  logic [NumRequesters-1:0]                         s_rready,
  output logic [DataWidth-1:0]                             s_rdata,
  output logic [TransactionIdWidth-1:0]                    s_rid,
  output response_e                                        s_rresp,

  input  logic [NumRequesters-1:0]                         s_awvalid,
  output logic [NumRequesters-1:0]                         s_awready,
  input  logic [NumRequesters-1:0][AddressWidth-1:0]       s_awaddr,
  input  logic [NumRequesters-1:0][TransactionIdWidth-1:0] s_awid,
  input  burst_size_t [NumRequesters-1:0]                  s_awsize,
  input  logic [NumRequesters-1:0]                         s_wvalid,
  output logic [NumRequesters-1:0]                         s_wready,
  input  logic [NumRequesters-1:0][DataWidth-1:0]          s_wdata,
  input  logic [NumRequesters-1:0][StrobeWidth-1:0]        s_wstrb,
  output logic [NumRequesters-1:0]                         s_bvalid,
  input  logic [NumRequesters-1:0]                         s_bready,
  output logic [TransactionIdWidth-1:0]                    s_bid,
  output response_e                                        s_bresp,

  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [AddressWidth-1:0]       m_araddr,
  output logic [TransactionIdWidth-1:0] m_arid,
  output burst_size_t                   m_arsize,
  output logic [7:0]                    m_arlen,
  output burst_type_t                   m_arburst,
  output logic                          m_arlock,
  output logic [2:0]                    m_arprot,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DataWidth-1:0]          m_rdata,
  input  logic [TransactionIdWidth-1:0] m_rid,
  input  response_e                     m_rresp,

  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [AddressWidth-1:0]       m_awaddr,
  output logic [TransactionIdWidth-1:0] m_awid,
  output burst_size_t                   m_awsize,
  output logic [7:0]                    m_awlen,
  output burst_type_t                   m_awburst,
  output logic                          m_awlock,
  output logic [2:0]                    m_awprot,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DataWidth-1:0]          m_wdata,
  output logic [StrobeWidth-1:0]        m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  input  logic [TransactionIdWidth-1:0] m_bid,
  input  response_e                     m_bresp,

  output logic          rd_busy,
  output logic          wr_busy,
  output logic [GW-1:0] rd_grant,
  output logic [GW-1:0] wr_grant
);

  arb_rd_state_e r_rd_state, w_rd_next;
  arb_wr_state_e r_wr_state, w_wr_next;

  logic [GW-1:0] r_rd_grant, r_wr_grant;
  logic [GW-1:0] w_rd_gidx, w_wr_gidx;
  logic          w_rd_gv, w_wr_gv;
  logic          w_rd_adv, w_wr_adv;
  logic          r_aw_done, r_w_done;
  logic          w_aw_hs, w_w_hs;

  assign w_rd_adv = (r_rd_state == RdIdle);
  assign w_wr_adv = (r_wr_state == WrIdle);

  renode_axi_rr_arbiter #(.N(NumRequesters)) u_rd_arb (
    .clk         (aclk),
    .rst         (areset),
    .req         (s_arvalid),
    .advance     (w_rd_adv),
    .grant_valid (w_rd_gv),
    .grant_idx   (w_rd_gidx)
  );

  renode_axi_rr_arbiter #(.N(NumRequesters)) u_wr_arb (
    .clk         (aclk),
    .rst         (areset),
    .req         (s_awvalid),
    .advance     (w_wr_adv),
    .grant_valid (w_wr_gv),
    .grant_idx   (w_wr_gidx)
  );

  assign m_arlen   = 8'd0;
  assign m_arburst = Incrementing;
  assign m_arlock  = 1'b0;
  assign m_arprot  = 3'd0;
  assign m_awlen   = 8'd0;
  assign m_awburst = Incrementing;
  assign m_awlock  = 1'b0;
  assign m_awprot  = 3'd0;
  assign m_wlast   = 1'b1;

  assign s_rdata = m_rdata;
  assign s_rid   = m_rid;
  assign s_rresp = m_rresp;
  assign s_bid   = m_bid;
  assign s_bresp = m_bresp;
  assign m_wdata = s_wdata[r_wr_grant];
  assign m_wstrb = s_wstrb[r_wr_grant];

  assign rd_busy  = (r_rd_state != RdIdle);
  assign wr_busy  = (r_wr_state != WrIdle);
  assign rd_grant = r_rd_grant;
  assign wr_grant = r_wr_grant;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_state <= RdIdle;
      r_rd_grant <= '0;
      m_araddr   <= '0;
      m_arid     <= '0;
      m_arsize   <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == RdIdle && w_rd_gv) begin
        r_rd_grant <= w_rd_gidx;
        m_araddr   <= s_araddr[w_rd_gidx];
        m_arid     <= s_arid[w_rd_gidx];
        m_arsize   <= s_arsize[w_rd_gidx];
      end
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    unique case (r_rd_state)
      RdIdle: if (w_rd_gv) w_rd_next = RdAddr;
      RdAddr: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          s_arready[r_rd_grant] = 1'b1;
          w_rd_next = RdResp;
        end
      end
      RdResp: begin
        s_rvalid[r_rd_grant] = m_rvalid;
        m_rready = s_rready[r_rd_grant];
        if (m_rvalid && s_rready[r_rd_grant]) w_rd_next = RdIdle;
      end
      default: w_rd_next = RdIdle;
    endcase
  end

  assign w_aw_hs = m_awvalid && m_awready;
  assign w_w_hs  = m_wvalid && m_wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_state <= WrIdle;
      r_wr_grant <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      m_awaddr   <= '0;
      m_awid     <= '0;
      m_awsize   <= '0;
    end else begin
      r_wr_state <= w_wr_next;
      if (r_wr_state == WrIdle && w_wr_gv) begin
        r_wr_grant <= w_wr_gidx;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        m_awaddr   <= s_awaddr[w_wr_gidx];
        m_awid     <= s_awid[w_wr_gidx];
        m_awsize   <= s_awsize[w_wr_gidx];
      end else if (r_wr_state == WrAddrData) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs) r_w_done <= 1'b1;
      end
    end
  end

  // AW and W complete independently; each side drops once its flag is set.
  always_comb begin
    w_wr_next = r_wr_state;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    unique case (r_wr_state)
      WrIdle: if (w_wr_gv) w_wr_next = WrAddrData;
      WrAddrData: begin
        m_awvalid = !r_aw_done;
        m_wvalid  = s_wvalid[r_wr_grant] && !r_w_done;
        s_awready[r_wr_grant] = m_awready && !r_aw_done;
        s_wready[r_wr_grant]  = m_wready && !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
          w_wr_next = WrResp;
      end
      WrResp: begin
        s_bvalid[r_wr_grant] = m_bvalid;
        m_bready = s_bready[r_wr_grant];
        if (m_bvalid && s_bready[r_wr_grant]) w_wr_next = WrIdle;
      end
      default: w_wr_next = WrIdle;
    endcase
  end

endmodule

// File: tb/tb_renode_axi_manager_arbiter.sv
// Directed bench for renode_axi_manager_arbiter with hand-driven
// subordinate responses and immediate-assertion checks.
module tb_renode_axi_manager_arbiter;
  import renode_axi_pkg::*;

  localparam int N = 4;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [N-1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N-1:0][31:0]  s_araddr;
  logic [N-1:0][7:0]   s_arid;
  burst_size_t [N-1:0] s_arsize;
  logic [31:0]         s_rdata;
  logic [7:0]          s_rid;
  response_e           s_rresp;
  logic [N-1:0]        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [N-1:0]        s_bvalid, s_bready;
  logic [N-1:0][31:0]  s_awaddr, s_wdata;
  logic [N-1:0][7:0]   s_awid;
  burst_size_t [N-1:0] s_awsize;
  logic [N-1:0][3:0]   s_wstrb;
  logic [7:0]          s_bid;
  response_e           s_bresp;

  logic        m_arvalid, m_arready, m_arlock;
  logic [31:0] m_araddr;
  logic [7:0]  m_arid, m_arlen;
  burst_size_t m_arsize;
  burst_type_t m_arburst;
  logic [2:0]  m_arprot;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [7:0]  m_rid;
  response_e   m_rresp;
  logic        m_awvalid, m_awready, m_awlock;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awid, m_awlen;
  burst_size_t m_awsize;
  burst_type_t m_awburst;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready, m_wlast;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [7:0]  m_bid;
  response_e   m_bresp;
  logic        rd_busy, wr_busy;
  logic [1:0]  rd_grant, wr_grant;

  int errors = 0;
  int checks = 0;

  renode_axi_manager_arbiter dut (
    .aclk(aclk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arsize(m_arsize), .m_arlen(m_arlen),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rid(m_rid), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_awid(m_awid), .m_awsize(m_awsize), .m_awlen(m_awlen),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
    .m_bresp(m_bresp),
    .rd_busy(rd_busy), .wr_busy(wr_busy),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_rready = '0; s_awvalid = '0;
    s_wvalid = '0; s_bready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_rid = '0; m_rresp = OKAY;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_bid = '0; m_bresp = OKAY;
  endtask

  initial begin
    int e;
    idle_inputs();
    s_araddr = '0; s_arid = '0; s_arsize = '0;
    s_awaddr = '0; s_awid = '0; s_awsize = '0;
    s_wdata = '0; s_wstrb = '0;
    tick();
    tick();
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_busy", {rd_busy, wr_busy}, 0);
    chk("rst_grants", {rd_grant, wr_grant}, 0);
    chk("rst_s_ready", {s_arready, s_awready, s_wready}, 0);
    areset = 1'b0;
    tick();

    // Single read from requester 2
    s_arvalid = 4'b0100;
    s_araddr[2] = 32'h100;
    s_arid[2] = 8'h07;
    s_arsize[2] = 3'd2;
    tick();
    chk("rd1_m_arvalid", m_arvalid, 1);
    chk("rd1_m_araddr", m_araddr, 32'h100);
    chk("rd1_m_arid", m_arid, 8'h07);
    chk("rd1_m_arsize", m_arsize, 3'd2);
    chk("rd1_m_arlen", m_arlen, 0);
    chk("rd1_m_arburst", m_arburst, 2'b01);
    chk("rd1_rd_grant", rd_grant, 2);
    chk("rd1_rd_busy", rd_busy, 1);
    chk("rd1_s_arready_wait", s_arready, 0);
    m_arready = 1'b1;
    #1;
    chk("rd1_s_arready", s_arready, 4'b0100);
    tick();
    s_arvalid = '0;
    m_arready = 1'b0;
    #1;
    chk("rd1_arvalid_drop", m_arvalid, 0);
    m_rvalid = 1'b1;
    m_rdata = 32'hDEADBEEF;
    m_rid = 8'h07;
    m_rresp = OKAY;
    s_rready = 4'b0100;
    #1;
    chk("rd1_s_rvalid", s_rvalid, 4'b0100);
    chk("rd1_s_rdata", s_rdata, 32'hDEADBEEF);
    chk("rd1_s_rresp", s_rresp, OKAY);
    chk("rd1_m_rready", m_rready, 1);
    tick();
    idle_inputs();
    #1;
    chk("rd1_done", rd_busy, 0);

    // Four simultaneous readers from pointer 0
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < N; i++) s_araddr[i] = 32'h1000 + 32'(i * 4);
    s_arvalid = 4'b1111;
    s_rready = 4'b1111;
    m_arready = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'h55AA55AA;
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      tick();
      chk("rr_grant", rd_grant, 64'(e));
      chk("rr_araddr", m_araddr, 32'h1000 + 32'(e * 4));
      chk("rr_s_arready", s_arready, 4'b0001 << e);
      tick();
      chk("rr_s_rvalid", s_rvalid, 4'b0001 << e);
      tick();
    end
    idle_inputs();

    // W from requester 1 before its AW
    s_wvalid = 4'b0010;
    s_wdata[1] = 32'hCAFEF00D;
    s_wstrb[1] = 4'hF;
    m_wready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wfirst_no_grant", {wr_busy, m_wvalid, m_awvalid}, 0);
      chk("wfirst_wready", s_wready, 0);
    end
    s_awvalid = 4'b0010;
    s_awaddr[1] = 32'h200;
    s_awid[1] = 8'h3C;
    tick();
    chk("wr_grant1", wr_grant, 1);
    chk("wr_m_awvalid", m_awvalid, 1);
    chk("wr_m_awaddr", m_awaddr, 32'h200);
    chk("wr_m_wvalid", m_wvalid, 1);
    chk("wr_m_wdata", m_wdata, 32'hCAFEF00D);
    chk("wr_m_wstrb", m_wstrb, 4'hF);
    chk("wr_m_wlast", m_wlast, 1);
    chk("wr_s_wready", s_wready, 4'b0010);
    chk("wr_s_awready_wait", s_awready, 0);
    tick();
    s_wvalid = '0;
    #1;
    chk("wr_w_done_drop", m_wvalid, 0);
    chk("wr_aw_hold", m_awvalid, 1);
    m_awready = 1'b1;
    #1;
    chk("wr_s_awready", s_awready, 4'b0010);
    tick();
    s_awvalid = '0;
    m_awready = 1'b0;
    m_bvalid = 1'b1;
    m_bid = 8'h3C;
    m_bresp = OKAY;
    s_bready = 4'b0010;
    #1;
    chk("wr_s_bvalid", s_bvalid, 4'b0010);
    chk("wr_s_bid", s_bid, 8'h3C);
    chk("wr_m_bready", m_bready, 1);
    tick();
    idle_inputs();
    #1;
    chk("wr_done", wr_busy, 0);

    // Concurrent read by 0 and write by 3, with SLVERR/rid passthrough
    s_arvalid = 4'b0001;
    s_araddr[0] = 32'h400;
    s_arid[0] = 8'h00;
    s_awvalid = 4'b1000;
    s_awaddr[3] = 32'h800;
    s_wvalid = 4'b1000;
    s_wdata[3] = 32'h0BADF00D;
    tick();
    chk("cc_busy", {rd_busy, wr_busy}, 2'b11);
    chk("cc_rd_grant", rd_grant, 0);
    chk("cc_wr_grant", wr_grant, 3);
    chk("cc_m_wdata", m_wdata, 32'h0BADF00D);
    m_arready = 1'b1;
    m_awready = 1'b1;
    m_wready = 1'b1;
    tick();
    idle_inputs();
    m_rvalid = 1'b1;
    m_rid = 8'h05;
    m_rresp = SLVERR;
    s_rready = 4'b0001;
    m_bvalid = 1'b1;
    s_bready = 4'b1000;
    #1;
    chk("cc_s_rvalid", s_rvalid, 4'b0001);
    chk("cc_s_rid", s_rid, 8'h05);
    chk("cc_s_rresp", s_rresp, SLVERR);
    chk("cc_s_bvalid", s_bvalid, 4'b1000);
    tick();
    idle_inputs();
    #1;
    chk("cc_done", {rd_busy, wr_busy}, 0);

    // Reset during read response, then a clean read
    s_arvalid = 4'b0010;
    s_araddr[1] = 32'h300;
    m_arready = 1'b1;
    tick();
    tick();
    s_arvalid = '0;
    m_arready = 1'b0;
    s_rready = 4'b0010;
    #1;
    chk("ab_resp_busy", {rd_busy, rd_grant}, 3'b101);
    chk("ab_m_rready", m_rready, 1);
    areset = 1'b1;
    #1;
    chk("ab_busy", rd_busy, 0);
    chk("ab_grant", rd_grant, 0);
    chk("ab_outs", {m_arvalid, m_rready, s_rvalid}, 0);
    tick();
    areset = 1'b0;
    s_rready = '0;
    s_arvalid = 4'b0010;
    m_arready = 1'b1;
    tick();
    chk("ab2_grant", rd_grant, 1);
    chk("ab2_araddr", m_araddr, 32'h300);
    tick();
    idle_inputs();
    m_rvalid = 1'b1;
    m_rdata = 32'h12345678;
    s_rready = 4'b0010;
    #1;
    chk("ab2_s_rvalid", s_rvalid, 4'b0010);
    chk("ab2_s_rdata", s_rdata, 32'h12345678);
    tick();
    idle_inputs();
    #1;
    chk("ab2_done", rd_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
